alu_decoder: RTL and testbench

ALU_DECODER -- requirements
Module: alu_decoder

---
 rtl/alu_decoder.sv | 106 ++++++++++
 tb/tb_alu_decoder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/alu_decoder.sv
// ============================================================================
// Module   : alu_decoder
// Purpose  : Registered ALU control decoder for an RV32I-subset datapath.
//            Flags unsupported operations instead of silently aliasing them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       funct7b5,
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic [1:0] ALUOp,
    input  logic       funct7b1,
    output logic [2:0] ALUControl,
    output logic       illegal
);

    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;
    localparam logic [2:0] c_alu_xor = 3'b100;
    localparam logic [2:0] c_alu_slt = 3'b101;
    localparam logic [2:0] c_alu_sll = 3'b110;
    localparam logic [2:0] c_alu_srl = 3'b111;

    localparam logic [1:0] c_aluop_mem    = 2'b00;
    localparam logic [1:0] c_aluop_branch = 2'b01;
    localparam logic [1:0] c_aluop_arith  = 2'b10;

    localparam logic [2:0] c_f3_addsub = 3'b000;
    localparam logic [2:0] c_f3_sll    = 3'b001;
    localparam logic [2:0] c_f3_slt    = 3'b010;
    localparam logic [2:0] c_f3_sltu   = 3'b011;
    localparam logic [2:0] c_f3_xor    = 3'b100;
    localparam logic [2:0] c_f3_srx    = 3'b101;
    localparam logic [2:0] c_f3_or     = 3'b110;

    logic       w_is_rtype_sub;
    logic       w_is_mext;
    logic [2:0] w_alu_control;
    logic       w_illegal;
    logic [2:0] r_alu_control;
    logic       r_illegal;

    // Only R-type may subtract; addi with bit 30 set is still an add.
    assign w_is_rtype_sub = opb5 & funct7b5;
    assign w_is_mext      = opb5 & funct7b1;

    always_comb begin
        w_alu_control = c_alu_add;
        w_illegal     = 1'b0;
        case (ALUOp)
            c_aluop_mem: begin
                w_alu_control = c_alu_add;
            end
            c_aluop_branch: begin
                w_alu_control = c_alu_sub;
            end
            c_aluop_arith: begin
                if (w_is_mext) begin
                    w_illegal = 1'b1;
                end else begin
                    case (funct3)
                        c_f3_addsub: w_alu_control = w_is_rtype_sub ? c_alu_sub : c_alu_add;
                        c_f3_sll:    w_alu_control = c_alu_sll;
                        c_f3_slt:    w_alu_control = c_alu_slt;
                        c_f3_sltu:   w_illegal     = 1'b1;
                        c_f3_xor:    w_alu_control = c_alu_xor;
                        c_f3_srx: begin
                            // funct7b5 selects sra/srai, which has no ALU code; flag it.
                            if (funct7b5) w_illegal     = 1'b1;
                            else          w_alu_control = c_alu_srl;
                        end
                        c_f3_or:     w_alu_control = c_alu_or;
                        default:     w_alu_control = c_alu_and;
                    endcase
                end
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
        // An illegal op must never leak a partially decoded code.
        if (w_illegal) w_alu_control = c_alu_add;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_control <= c_alu_add;
            r_illegal     <= 1'b0;
        end else begin
            r_alu_control <= w_alu_control;
            r_illegal     <= w_illegal;
        end
    end

    assign ALUControl = r_alu_control;
    assign illegal    = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_decoder.sv
// Directed and exhaustive checks of alu_decoder against hand-derived results.
`timescale 1ns/1ps
`default_nettype none

module tb_alu_decoder;

    logic       clk;
    logic       rst_n;
    logic       funct7b5;
    logic       opb5;
    logic [2:0] funct3;
    logic [1:0] ALUOp;
    logic       funct7b1;
    logic [2:0] ALUControl;
    logic       illegal;

    int n_checks = 0;
    int n_pass   = 0;

    alu_decoder u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .funct7b5   (funct7b5),
        .opb5       (opb5),
        .funct3     (funct3),
        .ALUOp      (ALUOp),
        .funct7b1   (funct7b1),
        .ALUControl (ALUControl),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got illegal/ctrl=%b/%b expected %b/%b",
                     tag, got[3], got[2:0], exp[3], exp[2:0]);
        end
    endtask

    // Independent reference: returns {illegal, ALUControl}.
    function automatic logic [3:0] expect_dec(input logic [1:0] op, input logic [2:0] f3,
                                              input logic ob5, input logic f75, input logic f71);
        if (op == 2'b00) return 4'b0_000;
        if (op == 2'b01) return 4'b0_001;
        if (op == 2'b11) return 4'b1_000;
        if (ob5 && f71)  return 4'b1_000;
        if (f3 == 3'b000) return (ob5 && f75) ? 4'b0_001 : 4'b0_000;
        if (f3 == 3'b001) return 4'b0_110;
        if (f3 == 3'b010) return 4'b0_101;
        if (f3 == 3'b011) return 4'b1_000;
        if (f3 == 3'b100) return 4'b0_100;
        if (f3 == 3'b101) return f75 ? 4'b1_000 : 4'b0_111;
        if (f3 == 3'b110) return 4'b0_011;
        return 4'b0_010;
    endfunction

    task automatic drive(input logic [1:0] op, input logic [2:0] f3,
                         input logic ob5, input logic f75, input logic f71);
        @(negedge clk);
        ALUOp    = op;
        funct3   = f3;
        opb5     = ob5;
        funct7b5 = f75;
        funct7b1 = f71;
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input string tag, input logic [1:0] op, input logic [2:0] f3,
                       input logic ob5, input logic f75, input logic f71, input logic [3:0] exp);
        drive(op, f3, ob5, f75, f71);
        check(tag, {illegal, ALUControl}, exp);
    endtask

    initial begin
        logic [7:0] v;
        rst_n    = 1'b0;
        ALUOp    = 2'b10;
        funct3   = 3'b100;
        opb5     = 1'b1;
        funct7b5 = 1'b0;
        funct7b1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", {illegal, ALUControl}, 4'b0_000);

        // Release between edges: outputs wait for the first edge.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_before_edge", {illegal, ALUControl}, 4'b0_000);
        @(posedge clk);
        #1;
        check("first_edge_xor", {illegal, ALUControl}, 4'b0_100);

        vec("rtype_sub",      2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 4'b0_001);
        vec("addi_bit30",     2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 4'b0_000);
        vec("srl",            2'b10, 3'b101, 1'b1, 1'b0, 1'b0, 4'b0_111);
        vec("sra_illegal",    2'b10, 3'b101, 1'b1, 1'b1, 1'b0, 4'b1_000);
        vec("srai_illegal",   2'b10, 3'b101, 1'b0, 1'b1, 1'b0, 4'b1_000);
        vec("mext_and",       2'b10, 3'b111, 1'b1, 1'b0, 1'b1, 4'b1_000);
        vec("andi_f7b1",      2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 4'b0_010);
        vec("sltu_illegal",   2'b10, 3'b011, 1'b1, 1'b0, 1'b0, 4'b1_000);
        vec("aluop11",        2'b11, 3'b110, 1'b0, 1'b0, 1'b0, 4'b1_000);
        vec("slli",           2'b10, 3'b001, 1'b0, 1'b0, 1'b0, 4'b0_110);
        vec("slti",           2'b10, 3'b010, 1'b0, 1'b1, 1'b0, 4'b0_101);

        // Mid-stream asynchronous reset discards the operation in flight.
        vec("or_before_rst",  2'b10, 3'b110, 1'b1, 1'b0, 1'b0, 4'b0_011);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", {illegal, ALUControl}, 4'b0_000);
        @(negedge clk);
        check("clear_held", {illegal, ALUControl}, 4'b0_000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reload_or", {illegal, ALUControl}, 4'b0_011);

        for (int i = 0; i < 8; i++) begin
            vec($sformatf("mem_rand%0d", i), 2'b00, 3'($urandom_range(7)),
                1'($urandom), 1'($urandom), 1'($urandom), 4'b0_000);
            vec($sformatf("br_rand%0d", i), 2'b01, 3'($urandom_range(7)),
                1'($urandom), 1'($urandom), 1'($urandom), 4'b0_001);
        end

        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            drive(v[7:6], v[5:3], v[2], v[1], v[0]);
            check($sformatf("sweep%0d", i), {illegal, ALUControl},
                  expect_dec(v[7:6], v[5:3], v[2], v[1], v[0]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
